cis_power_down: RTL and testbench

Power-down sequencer for the CMOS image sensor (CIS) supply and control pins; the mirror of the power-up sequencer. It sits between the power-up sequencer outputs and the sensor pins. While idle it registers the power-up sequencer's pin values through unchanged. On a shutdown request it drives the pins off in exact reverse order, with programmable gaps, and reports completion.

---
 rtl/cis_power_down_pkg.sv | 23 ++
 rtl/cis_power_down_pd_timer.sv | 28 ++
 rtl/cis_power_down.sv | 202 ++++++++++++++++++++
 tb/tb_cis_power_down.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cis_power_down_pkg.sv
// Shared definitions for the CIS power-down sequencer: FSM states and the
// pin levels the sensor sits at while unpowered (also used by power-up).
package cis_power_down_pkg;

   typedef enum logic [2:0] {
      PASS,
      DRAIN,
      RST_LOW,
      PWDN_HI,
      OFF_1V5,
      OFF_3V0,
      OFF_2V8,
      DONE
   } pdState_e;

   localparam logic PIN_EN_CIS2V8_RST       = 1'b0;
   localparam logic PIN_EN_CISA3V0_RST      = 1'b0;
   localparam logic PIN_EN_CIS1V5_RST       = 1'b0;
   localparam logic PIN_CIS_PWDN_RST        = 1'b1;
   localparam logic PIN_CIS_RST_RST         = 1'b0;
   localparam logic PIN_CIS_I2C_STANDBY_RST = 1'b0;

endpackage

// File: rtl/cis_power_down_pd_timer.sv
// Delay counter for the power-down sequencer. It restarts from zero whenever
// clear_i is high and otherwise counts up; done_o flags the count matching
// the limit the sequencer presents for its current state.
module cis_pd_timer #(
   parameter int CNT_W = 21
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             done_o
);

   logic [CNT_W-1:0] count_q;

   // Count cycles spent in a wait state, restarting on every state change.
   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         count_q <= '0;
      end else if (enable_i) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign done_o = (count_q == limit_i);

endmodule

// File: rtl/cis_power_down.sv
// CIS power-down sequencer. Passes the power-up sequencer's pins through
// (one register stage) until a shutdown request is accepted, then drains the
// I2C bus and turns the sensor off in reverse power-up order.
module cis_power_down
   import cis_power_down_pkg::*;
#(
   parameter int delay_t4 = 1000000,
   parameter int delay_t3 = 50000,
   parameter int delay_t2 = 250000,
   parameter int delay_t1 = 25000,
   parameter int delay_t0 = 25000,
   parameter int CNT_W    = 21
) (
   input  logic clock,
   input  logic reset,
   input  logic pd_req,
   input  logic i2c_busy,
   input  logic up_en_cis2v8,
   input  logic up_en_cisa3v0,
   input  logic up_en_cis1v5,
   input  logic up_cis_pwdn,
   input  logic up_cis_rst,
   input  logic up_cis_i2c_standby,
   output logic en_cis2v8,
   output logic en_cisa3v0,
   output logic en_cis1v5,
   output logic cis_pwdn,
   output logic cis_rst,
   output logic cis_i2c_standby,
   output logic pd_busy,
   output logic pd_done,
   output logic i2c_timeout
);

   // The drain timeout fires when the count equals delay_t4 itself, so the
   // reset pin falls delay_t4+1 cycles after standby drops. The fixed waits
   // exit at delay-1 so each pin edge lands exactly delay cycles apart.
   localparam logic [CNT_W-1:0] LIM_T4 = CNT_W'(delay_t4);
   localparam logic [CNT_W-1:0] LIM_T3 = CNT_W'(delay_t3 - 1);
   localparam logic [CNT_W-1:0] LIM_T2 = CNT_W'(delay_t2 - 1);
   localparam logic [CNT_W-1:0] LIM_T1 = CNT_W'(delay_t1 - 1);
   localparam logic [CNT_W-1:0] LIM_T0 = CNT_W'(delay_t0 - 1);

   pdState_e         state_q;
   logic             enCis2v8_q;
   logic             enCisa3v0_q;
   logic             enCis1v5_q;
   logic             cisPwdn_q;
   logic             cisRst_q;
   logic             cisI2cStandby_q;
   logic             pdBusy_q;
   logic             pdDone_q;
   logic             i2cTimeout_q;

   logic [CNT_W-1:0] timerLimit;
   logic             timerDone;
   logic             timerClear;
   logic             exitNow;

   // Decide whether the current state ends this cycle and which limit the
   // timer compares against while in it.
   always_comb begin
      timerLimit = '0;
      exitNow    = 1'b0;
      case (state_q)
         PASS:    exitNow = pd_req && up_cis_i2c_standby;
         DRAIN: begin
            timerLimit = LIM_T4;
            exitNow    = !i2c_busy || timerDone;
         end
         RST_LOW: begin
            timerLimit = LIM_T3;
            exitNow    = timerDone;
         end
         PWDN_HI: begin
            timerLimit = LIM_T2;
            exitNow    = timerDone;
         end
         OFF_1V5: begin
            timerLimit = LIM_T1;
            exitNow    = timerDone;
         end
         OFF_3V0: begin
            timerLimit = LIM_T0;
            exitNow    = timerDone;
         end
         OFF_2V8: exitNow = 1'b1;
         DONE:    exitNow = 1'b0;
         default: exitNow = 1'b0;
      endcase
   end

   // The timer restarts on every state entry and idles at zero outside the
   // wait states.
   assign timerClear = exitNow || (state_q == PASS) || (state_q == DONE) ||
                       (state_q == OFF_2V8);

   cis_pd_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (timerClear),
      .enable_i (!timerClear),
      .limit_i  (timerLimit),
      .done_o   (timerDone)
   );

   // Sequencer: pass-through while idle, then one pin change per state
   // transition so every output edge is registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= PASS;
         enCis2v8_q      <= PIN_EN_CIS2V8_RST;
         enCisa3v0_q     <= PIN_EN_CISA3V0_RST;
         enCis1v5_q      <= PIN_EN_CIS1V5_RST;
         cisPwdn_q       <= PIN_CIS_PWDN_RST;
         cisRst_q        <= PIN_CIS_RST_RST;
         cisI2cStandby_q <= PIN_CIS_I2C_STANDBY_RST;
         pdBusy_q        <= 1'b0;
         pdDone_q        <= 1'b0;
         i2cTimeout_q    <= 1'b0;
      end else begin
         case (state_q)
            PASS: begin
               enCis2v8_q      <= up_en_cis2v8;
               enCisa3v0_q     <= up_en_cisa3v0;
               enCis1v5_q      <= up_en_cis1v5;
               cisPwdn_q       <= up_cis_pwdn;
               cisRst_q        <= up_cis_rst;
               cisI2cStandby_q <= up_cis_i2c_standby;
               if (exitNow) begin
                  cisI2cStandby_q <= 1'b0;
                  pdBusy_q        <= 1'b1;
                  state_q         <= DRAIN;
               end
            end
            DRAIN: begin
               if (exitNow) begin
                  cisRst_q <= 1'b0;
                  if (i2c_busy) begin
                     i2cTimeout_q <= 1'b1;
                  end
                  state_q <= RST_LOW;
               end
            end
            RST_LOW: begin
               if (exitNow) begin
                  cisPwdn_q <= 1'b1;
                  state_q   <= PWDN_HI;
               end
            end
            PWDN_HI: begin
               if (exitNow) begin
                  enCis1v5_q <= 1'b0;
                  state_q    <= OFF_1V5;
               end
            end
            OFF_1V5: begin
               if (exitNow) begin
                  enCisa3v0_q <= 1'b0;
                  state_q     <= OFF_3V0;
               end
            end
            OFF_3V0: begin
               if (exitNow) begin
                  enCis2v8_q <= 1'b0;
                  state_q    <= OFF_2V8;
               end
            end
            OFF_2V8: begin
               enCis2v8_q      <= PIN_EN_CIS2V8_RST;
               enCisa3v0_q     <= PIN_EN_CISA3V0_RST;
               enCis1v5_q      <= PIN_EN_CIS1V5_RST;
               cisPwdn_q       <= PIN_CIS_PWDN_RST;
               cisRst_q        <= PIN_CIS_RST_RST;
               cisI2cStandby_q <= PIN_CIS_I2C_STANDBY_RST;
               pdBusy_q        <= 1'b0;
               pdDone_q        <= 1'b1;
               state_q         <= DONE;
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= PASS;
            end
         endcase
      end
   end

   assign en_cis2v8       = enCis2v8_q;
   assign en_cisa3v0      = enCisa3v0_q;
   assign en_cis1v5       = enCis1v5_q;
   assign cis_pwdn        = cisPwdn_q;
   assign cis_rst         = cisRst_q;
   assign cis_i2c_standby = cisI2cStandby_q;
   assign pd_busy         = pdBusy_q;
   assign pd_done         = pdDone_q;
   assign i2c_timeout     = i2cTimeout_q;

endmodule

// File: tb/tb_cis_power_down.sv
// Directed bench for the CIS power-down sequencer with short delays.
// Pin vectors are packed {en_cis2v8, en_cisa3v0, en_cis1v5, cis_pwdn,
// cis_rst, cis_i2c_standby}.
module tb_cis_power_down;

   localparam logic [5:0] PINS_RESET = 6'b000100;
   localparam logic [5:0] PINS_UP    = 6'b111011;

   logic clock;
   logic reset;
   logic pd_req;
   logic i2c_busy;
   logic up_en_cis2v8;
   logic up_en_cisa3v0;
   logic up_en_cis1v5;
   logic up_cis_pwdn;
   logic up_cis_rst;
   logic up_cis_i2c_standby;
   logic en_cis2v8;
   logic en_cisa3v0;
   logic en_cis1v5;
   logic cis_pwdn;
   logic cis_rst;
   logic cis_i2c_standby;
   logic pd_busy;
   logic pd_done;
   logic i2c_timeout;

   int assertCount;
   int failCount;

   logic [5:0] pins;
   assign pins = {en_cis2v8, en_cisa3v0, en_cis1v5, cis_pwdn, cis_rst, cis_i2c_standby};

   cis_power_down #(
      .delay_t4 (20),
      .delay_t3 (5),
      .delay_t2 (7),
      .delay_t1 (3),
      .delay_t0 (4),
      .CNT_W    (21)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .pd_req             (pd_req),
      .i2c_busy           (i2c_busy),
      .up_en_cis2v8       (up_en_cis2v8),
      .up_en_cisa3v0      (up_en_cisa3v0),
      .up_en_cis1v5       (up_en_cis1v5),
      .up_cis_pwdn        (up_cis_pwdn),
      .up_cis_rst         (up_cis_rst),
      .up_cis_i2c_standby (up_cis_i2c_standby),
      .en_cis2v8          (en_cis2v8),
      .en_cisa3v0         (en_cisa3v0),
      .en_cis1v5          (en_cis1v5),
      .cis_pwdn           (cis_pwdn),
      .cis_rst            (cis_rst),
      .cis_i2c_standby    (cis_i2c_standby),
      .pd_busy            (pd_busy),
      .pd_done            (pd_done),
      .i2c_timeout        (i2c_timeout)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance n clock edges, landing 1 unit after the last edge.
   task automatic stepCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic req, input logic busy, input logic [5:0] up);
      pd_req   = req;
      i2c_busy = busy;
      {up_en_cis2v8, up_en_cisa3v0, up_en_cis1v5, up_cis_pwdn, up_cis_rst, up_cis_i2c_standby} = up;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_pins"}, {2'b00, pins}, {2'b00, PINS_RESET});
      checkOutput({tag, "_flags"}, {5'b0, pd_busy, pd_done, i2c_timeout}, 8'h00);
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      assertCount = 0;
      failCount   = 0;
      reset       = 1'b1;
      applyStimulus(1'b0, 1'b0, 6'b000000);
      stepCycles(2);
      checkResetState("reset");

      // Normal shutdown with an idle I2C bus.
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, PINS_UP);
      stepCycles(1);
      checkOutput("pass_up", {2'b00, pins}, {2'b00, PINS_UP});
      applyStimulus(1'b1, 1'b0, PINS_UP);
      stepCycles(1);
      checkOutput("accept_pins", {2'b00, pins}, {2'b00, 6'b111010});
      checkOutput("accept_busy", {7'b0, pd_busy}, 8'h01);
      applyStimulus(1'b0, 1'b0, PINS_UP);
      stepCycles(1);
      checkOutput("rst_low", {2'b00, pins}, {2'b00, 6'b111000});
      stepCycles(4);
      checkOutput("pwdn_early", {2'b00, pins}, {2'b00, 6'b111000});
      stepCycles(1);
      checkOutput("pwdn_hi", {2'b00, pins}, {2'b00, 6'b111100});
      stepCycles(6);
      checkOutput("off1v5_early", {2'b00, pins}, {2'b00, 6'b111100});
      stepCycles(1);
      checkOutput("off1v5", {2'b00, pins}, {2'b00, 6'b110100});
      stepCycles(2);
      checkOutput("off3v0_early", {2'b00, pins}, {2'b00, 6'b110100});
      stepCycles(1);
      checkOutput("off3v0", {2'b00, pins}, {2'b00, 6'b100100});
      stepCycles(3);
      checkOutput("off2v8_early", {2'b00, pins}, {2'b00, 6'b100100});
      stepCycles(1);
      checkOutput("off2v8", {2'b00, pins}, {2'b00, 6'b000100});
      checkOutput("off2v8_flags", {5'b0, pd_busy, pd_done, i2c_timeout}, 8'b100);
      stepCycles(1);
      checkOutput("done_flags", {5'b0, pd_busy, pd_done, i2c_timeout}, 8'b010);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0], 1'b0, PINS_UP);
         stepCycles(1);
         checkOutput("done_hold", {1'b0, pd_done, pins}, {1'b0, 1'b1, PINS_RESET});
      end

      // Drain waits for I2C to go idle; no timeout.
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, PINS_UP);
      stepCycles(1);
      checkResetState("reset_after_done");
      reset = 1'b0;
      stepCycles(1);
      applyStimulus(1'b1, 1'b1, PINS_UP);
      stepCycles(1);
      applyStimulus(1'b0, 1'b1, PINS_UP);
      stepCycles(10);
      checkOutput("drain_wait", {2'b00, pins}, {2'b00, 6'b111010});
      applyStimulus(1'b0, 1'b0, PINS_UP);
      stepCycles(1);
      checkOutput("drain_release", {2'b00, pins}, {2'b00, 6'b111000});
      checkOutput("drain_no_timeout", {7'b0, i2c_timeout}, 8'h00);

      // I2C stuck busy: timeout after delay_t4+1 cycles.
      reset = 1'b1;
      stepCycles(1);
      reset = 1'b0;
      stepCycles(1);
      applyStimulus(1'b1, 1'b1, PINS_UP);
      stepCycles(1);
      applyStimulus(1'b0, 1'b1, PINS_UP);
      stepCycles(20);
      checkOutput("timeout_early", {6'b0, cis_rst, i2c_timeout}, 8'b10);
      stepCycles(1);
      checkOutput("timeout_fire", {6'b0, cis_rst, i2c_timeout}, 8'b01);
      stepCycles(4);
      checkOutput("timeout_pwdn_early", {7'b0, cis_pwdn}, 8'h00);
      stepCycles(1);
      checkOutput("timeout_pwdn", {7'b0, cis_pwdn}, 8'h01);
      stepCycles(7 + 3 + 4 + 1);
      checkOutput("timeout_done", {5'b0, pd_busy, pd_done, i2c_timeout}, 8'b011);

      // Request held before power-up finishes; pins keep tracking.
      reset = 1'b1;
      stepCycles(1);
      checkResetState("reset_after_timeout");
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 6'b111010);
      stepCycles(1);
      checkOutput("early_track", {1'b0, pd_busy, pins}, {1'b0, 1'b0, 6'b111010});
      applyStimulus(1'b1, 1'b0, 6'b111000);
      stepCycles(1);
      checkOutput("early_track_rst", {1'b0, pd_busy, pins}, {1'b0, 1'b0, 6'b111000});
      applyStimulus(1'b1, 1'b0, PINS_UP);
      stepCycles(1);
      checkOutput("early_accept", {1'b0, pd_busy, pins}, {1'b0, 1'b1, 6'b111010});

      // Reset while in OFF_1V5 returns straight to reset values and PASS.
      stepCycles(1 + 5 + 7);
      checkOutput("mid_off1v5", {2'b00, pins}, {2'b00, 6'b110100});
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, PINS_UP);
      stepCycles(1);
      checkResetState("reset_mid");
      reset = 1'b0;
      stepCycles(1);
      checkOutput("pass_after_reset", {1'b0, pd_busy, pins}, {1'b0, 1'b0, PINS_UP});

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
